// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage. Drives a handshaked data-memory port from the EX/MEM
//   register, resolves the branch/jump PC select, stalls upstream while an
//   access is outstanding (bounded by a timeout), and registers MEM/WB.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When defined, a memop whose address is not word aligned issues no request,
//   does not stall, commits a bubble and pulses misalign_err for one cycle.
//
// Ports:
//   CLK, RST                 clock, async active-low reset
//   valid_in ... regdst_in   EX/MEM register contents
//   dmem_*                   data-memory request/ack port
//   stall                    freeze PC, IF/ID, ID/EX, EX/MEM
//   PCSrc, branch_target_out next-PC select and target
//   MEMRegRd, MEM_RegWrite   forwarding taps
//   wb_valid ... regdst_out  MEM/WB register
//   bus_error                one-cycle pulse after a timeout abort
//   misalign_err             (MEM_ALIGN_CHECK_EN only) misaligned access pulse
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        aluzero_in,
    input  logic [31:0] branch_target_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] readdata2_in,
    input  logic [4:0]  regdst_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] branch_target_out,
    output logic [4:0]  MEMRegRd,
    output logic        MEM_RegWrite,
    output logic        wb_valid,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] memdata_out,
    output logic [31:0] alu_out,
    output logic [4:0]  regdst_out,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        bus_error
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort;
    logic             misalign;
    logic             memop;
    logic             is_read;

    logic             wb_valid_q, regwrite_q, memtoreg_q, bus_error_q;
    logic [31:0]      memdata_q, alu_q;
    logic [4:0]       regdst_q;

`ifdef MEM_ALIGN_CHECK_EN
    logic             misalign_q;
    assign misalign = valid_in & (MemRead_in | MemWrite_in) & (|alu_in[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned access is not a memop: no request, no stall.
    assign memop   = valid_in & (MemRead_in | MemWrite_in) & ~misalign;
    // Read+write together is treated as a write, so it returns no load data.
    assign is_read = valid_in & MemRead_in & ~MemWrite_in;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (memop && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                // Leaving WAIT if the instruction vanished is defensive only;
                // upstream holds EX/MEM while stalled.
                if (dmem_ack || abort || !memop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Request, stall and abort are all forced low while reset is asserted.
    always_comb begin
        dmem_req = 1'b0;
        stall    = 1'b0;
        abort    = 1'b0;
        if (RST) begin
            case (state_q)
                IDLE: begin
                    dmem_req = memop;
                    stall    = memop & ~dmem_ack;
                end
                WAIT: begin
                    dmem_req = 1'b1;
                    abort    = ~dmem_ack & (cnt_q >= TMO);
                    stall    = memop & ~dmem_ack & ~abort;
                end
                default: ;
            endcase
        end
    end

    // ---------------- memory port / PC select ----------------
    assign dmem_we           = MemWrite_in;
    assign dmem_addr         = alu_in;
    assign dmem_wdata        = readdata2_in;
    assign PCSrc             = RST & ~stall & valid_in & ((branch_in & aluzero_in) | jump_in);
    assign branch_target_out = branch_target_in;
    assign MEMRegRd          = regdst_in;
    assign MEM_RegWrite      = RegWrite_in & valid_in;

    // ---------------- MEM/WB register ----------------
    // Stall, abort and misalign each load a bubble; data fields hold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wb_valid_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            memdata_q   <= '0;
            alu_q       <= '0;
            regdst_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= abort;
            if (stall || abort || misalign) begin
                wb_valid_q <= 1'b0;
                regwrite_q <= 1'b0;
            end else begin
                wb_valid_q <= valid_in;
                regwrite_q <= RegWrite_in & valid_in;
                memtoreg_q <= MemtoReg_in;
                alu_q      <= alu_in;
                regdst_q   <= regdst_in;
                memdata_q  <= is_read ? dmem_rdata : 32'h0;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) misalign_q <= 1'b0;
        else      misalign_q <= misalign;
    end
    assign misalign_err = misalign_q;
`endif

    assign wb_valid     = wb_valid_q;
    assign RegWrite_out = regwrite_q;
    assign MemtoReg_out = memtoreg_q;
    assign memdata_out  = memdata_q;
    assign alu_out      = alu_q;
    assign regdst_out   = regdst_q;
    assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        valid_in, branch_in, jump_in, MemRead_in, MemWrite_in;
    logic        RegWrite_in, MemtoReg_in, aluzero_in;
    logic [31:0] branch_target_in, alu_in, readdata2_in, dmem_rdata;
    logic [4:0]  regdst_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, PCSrc, MEM_RegWrite;
    logic [31:0] dmem_addr, dmem_wdata, branch_target_out, memdata_out, alu_out;
    logic [4:0]  MEMRegRd, regdst_out;
    logic        wb_valid, RegWrite_out, MemtoReg_out, bus_error;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .valid_in(valid_in), .branch_in(branch_in), .jump_in(jump_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .aluzero_in(aluzero_in), .branch_target_in(branch_target_in),
        .alu_in(alu_in), .readdata2_in(readdata2_in), .regdst_in(regdst_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .PCSrc(PCSrc), .branch_target_out(branch_target_out),
        .MEMRegRd(MEMRegRd), .MEM_RegWrite(MEM_RegWrite),
        .wb_valid(wb_valid), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .memdata_out(memdata_out),
        .alu_out(alu_out), .regdst_out(regdst_out),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .bus_error(bus_error)
    );

    // Stimulus-only helper: drive a bubble with quiet memory.
    task automatic drive_idle();
        valid_in = 0; branch_in = 0; jump_in = 0; MemRead_in = 0; MemWrite_in = 0;
        RegWrite_in = 0; MemtoReg_in = 0; aluzero_in = 0;
        branch_target_in = 0; alu_in = 0; readdata2_in = 0; regdst_in = 0;
        dmem_rdata = 0; dmem_ack = 0;
    endtask

    task automatic test_reset();
        RST = 0;
        drive_idle();
        valid_in = 1; MemRead_in = 1; jump_in = 1;
        #2;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", dmem_req); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall); end
        checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL reset_pcsrc got=%b want=0", PCSrc); end
        checks++; if ({wb_valid, RegWrite_out, MemtoReg_out, bus_error} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b want=0000", {wb_valid, RegWrite_out, MemtoReg_out, bus_error}); end
        checks++; if ({memdata_out, alu_out, regdst_out} !== 69'h0) begin failures++; $display("FAIL reset_data got=%h want=0", {memdata_out, alu_out, regdst_out}); end
        @(negedge CLK);
        drive_idle();
        RST = 1;
        @(negedge CLK);
    endtask

    task automatic test_alu();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; RegWrite_in = 1; alu_in = 32'h10; regdst_in = 5;
        dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;  // stray ack must be ignored
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b want=0", stall); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL alu_req got=%b want=0", dmem_req); end
        checks++; if (MEM_RegWrite !== 1'b1 || MEMRegRd !== 5'd5) begin failures++; $display("FAIL alu_fwd got=%b/%0d want=1/5", MEM_RegWrite, MEMRegRd); end
        @(posedge CLK); #1;
        checks++; if ({wb_valid, RegWrite_out} !== 2'b11) begin failures++; $display("FAIL alu_wbctl got=%b want=11", {wb_valid, RegWrite_out}); end
        checks++; if (alu_out !== 32'h10 || regdst_out !== 5'd5) begin failures++; $display("FAIL alu_wbdata got=%h/%0d want=10/5", alu_out, regdst_out); end
        checks++; if (memdata_out !== 32'h0) begin failures++; $display("FAIL alu_memdata got=%h want=0", memdata_out); end
    endtask

    task automatic test_load_fast();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1;
        alu_in = 32'h100; regdst_in = 7; dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL ldf_req_stall got=%b%b want=10", dmem_req, stall); end
        checks++; if (dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin failures++; $display("FAIL ldf_port got=%b/%h want=0/100", dmem_we, dmem_addr); end
        @(posedge CLK); #1;
        checks++; if (memdata_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ldf_memdata got=%h want=deadbeef", memdata_out); end
        checks++; if ({wb_valid, RegWrite_out, MemtoReg_out} !== 3'b111) begin failures++; $display("FAIL ldf_wbctl got=%b want=111", {wb_valid, RegWrite_out, MemtoReg_out}); end
    endtask

    task automatic test_store_wait();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; MemWrite_in = 1; alu_in = 32'h104; readdata2_in = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge CLK);
            dmem_ack = (k == 3);
            #1;
            checks++; if (stall !== (k != 3)) begin failures++; $display("FAIL st_stall k=%0d got=%b want=%b", k, stall, (k != 3)); end
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h1234) begin failures++; $display("FAIL st_port k=%0d got=%b%b/%h want=11/1234", k, dmem_req, dmem_we, dmem_wdata); end
            @(posedge CLK); #1;
            checks++; if (wb_valid !== (k == 3)) begin failures++; $display("FAIL st_wbvalid k=%0d got=%b want=%b", k, wb_valid, (k == 3)); end
        end
        checks++; if (alu_out !== 32'h104 || memdata_out !== 32'h0 || RegWrite_out !== 1'b0) begin failures++; $display("FAIL st_commit got=%h/%h/%b want=104/0/0", alu_out, memdata_out, RegWrite_out); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        @(negedge CLK);
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; alu_in = 32'h200;
        #1;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(posedge CLK); #1;
            if (wb_valid !== 1'b0) begin checks++; failures++; $display("FAIL to_bubble cyc=%0d got=%b want=0", n, wb_valid); end
            @(negedge CLK); #1;
        end
        checks++; if (n != 16) begin failures++; $display("FAIL to_stall_len got=%0d want=16", n); end
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL to_abort_cycle got=%b%b want=10", dmem_req, stall); end
        @(posedge CLK); #1;
        checks++; if (bus_error !== 1'b1) begin failures++; $display("FAIL to_buserr got=%b want=1", bus_error); end
        checks++; if (wb_valid !== 1'b0 || RegWrite_out !== 1'b0) begin failures++; $display("FAIL to_wb got=%b%b want=00", wb_valid, RegWrite_out); end
        @(negedge CLK);
        drive_idle();
        #1;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL to_idle_req got=%b want=0", dmem_req); end
        @(posedge CLK); #1;
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL to_buserr_pulse got=%b want=0", bus_error); end
    endtask

    task automatic test_branch();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; branch_in = 1; aluzero_in = 1; branch_target_in = 32'h40;
        #1;
        checks++; if (PCSrc !== 1'b1 || branch_target_out !== 32'h40) begin failures++; $display("FAIL br_taken got=%b/%h want=1/40", PCSrc, branch_target_out); end
        aluzero_in = 0;
        #1;
        checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL br_nottaken got=%b want=0", PCSrc); end
        branch_in = 0; jump_in = 1;
        #1;
        checks++; if (PCSrc !== 1'b1) begin failures++; $display("FAIL br_jump got=%b want=1", PCSrc); end
        valid_in = 0;
        #1;
        checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL br_bubble got=%b want=0", PCSrc); end
        // Taken branch alongside a stalled load: PC select suppressed.
        valid_in = 1; jump_in = 0; branch_in = 1; aluzero_in = 1; MemRead_in = 1;
        #1;
        checks++; if (stall !== 1'b1 || PCSrc !== 1'b0) begin failures++; $display("FAIL br_stall got=%b%b want=10", stall, PCSrc); end
        dmem_ack = 1; dmem_rdata = 32'h55;
        #1;
        checks++; if (PCSrc !== 1'b1) begin failures++; $display("FAIL br_ackd got=%b want=1", PCSrc); end
        @(posedge CLK); #1;
        checks++; if (memdata_out !== 32'h55) begin failures++; $display("FAIL br_ld got=%h want=55", memdata_out); end
    endtask

    task automatic test_rw_both();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; MemRead_in = 1; MemWrite_in = 1; alu_in = 32'h300;
        dmem_ack = 1; dmem_rdata = 32'hAAAA_AAAA;
        #1;
        checks++; if (dmem_we !== 1'b1) begin failures++; $display("FAIL rw_we got=%b want=1", dmem_we); end
        @(posedge CLK); #1;
        checks++; if (memdata_out !== 32'h0 || wb_valid !== 1'b1) begin failures++; $display("FAIL rw_commit got=%h/%b want=0/1", memdata_out, wb_valid); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; alu_in = 32'h400; regdst_in = 9;
        @(posedge CLK);
        @(negedge CLK); #1;
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL rmw_wait got=%b%b want=11", dmem_req, stall); end
        checks++; if (alu_out !== 32'h300) begin failures++; $display("FAIL rmw_hold got=%h want=300", alu_out); end
        #1 RST = 0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rmw_async got=%b%b want=00", dmem_req, stall); end
        checks++; if ({wb_valid, RegWrite_out, MemtoReg_out, memdata_out, alu_out, regdst_out} !== 72'h0) begin failures++; $display("FAIL rmw_wbclr got=%h want=0", {wb_valid, RegWrite_out, MemtoReg_out, memdata_out, alu_out, regdst_out}); end
        drive_idle();
        @(negedge CLK);
        RST = 1;
        #1;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rmw_idle got=%b want=0", dmem_req); end
        @(posedge CLK); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rmw_bubble got=%b want=0", wb_valid); end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        @(negedge CLK);
        drive_idle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; alu_in = 32'h101;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mis_req got=%b%b want=00", dmem_req, stall); end
        @(posedge CLK); #1;
        checks++; if (misalign_err !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b/%b want=1/0", misalign_err, wb_valid); end
        @(negedge CLK);
        drive_idle();
        @(posedge CLK); #1;
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b want=0", misalign_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load_fast();
        test_store_wait();
        test_timeout();
        test_branch();
        test_rw_both();
        test_reset_mid_wait();
`ifdef MEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
